obstacle_datapath: RTL and testbench
====================================

OBSTACLE_DATAPATH -- requirements
Module: obstacle_datapath

Interface
REQ-001 The block SHALL have the following parameters; each line gives name, default and meaning:
- TICK_CYCLES, 833333: clock cycles per movement tick.
- X_START, 0: object start x.
- Y_START, 56: object start y.
- X_END, 156: x at which the run is complete.
- OBS_X, 80: obstacle left edge.
- OBS_Y, 48: obstacle top edge.
- OBS_SIZE, 16: obstacle side length.
- OBJ_COLOUR, 3'b010: object colour.
REQ-002 The block SHALL have the following ports; each line gives name, direction, width and meaning:
- clock, in, 1: system clock.
- resetn, in, 1: reset, synchronous, active-low.
- draw, in, 1: run enable from the control FSM.
- writeEnable, in, 1: gates the plot output.
- up, in, 1: player moves up.
- down, in, 1: player moves down.
- x, out, 8: pixel x for the VGA adapter.
- y, out, 7: pixel y for the VGA adapter.
- colour, out, 3: pixel colour.
- plot, out, 1: pixel write strobe.
- finish, out, 1: end reached or collision; feeds the control FSM.
- collided, out, 1: finish was caused by a collision.

Function
REQ-003 The object SHALL be a 4x4 square whose top-left corner is at (xp[7:0], yp[6:0]).
REQ-004 The engine FSM SHALL have states IDLE, WAIT, ERASE, UPDATE, DRAW, CHECK, DONE.
REQ-005 State transitions SHALL be:
- IDLE -> DRAW when draw=1.
- WAIT -> ERASE on tick.
- ERASE -> UPDATE after 16 cycles.
- UPDATE -> DRAW after 1 cycle.
- DRAW -> CHECK after 16 cycles.
- CHECK -> DONE if the finish condition holds, else -> WAIT.
- DONE holds until reset.
REQ-006 In any state other than DONE, draw=0 SHALL force IDLE on the next cycle; the pixel counter and tick counter clear, and xp and yp are held.
REQ-007 The tick counter SHALL count 0..TICK_CYCLES-1 only in WAIT, and tick SHALL be asserted when count==TICK_CYCLES-1; the counter clears on leaving WAIT.
REQ-008 A 4-bit pixel counter p SHALL run 0..15 in ERASE and DRAW; the pixel outputs are x=xp+p[1:0] and y=yp+p[3:2].
REQ-009 colour SHALL be 3'b000 in ERASE and OBJ_COLOUR in DRAW; colour is don't-care elsewhere.
REQ-010 plot SHALL equal writeEnable AND (state is ERASE or DRAW), combinationally, and SHALL be 0 in all other states.
REQ-011 In UPDATE, xp SHALL be incremented by 1.
REQ-012 In UPDATE, yp SHALL be updated as follows:
- up=1, down=0, yp>0: yp-1.
- down=1, up=0, yp<116: yp+1.
- otherwise (both asserted, neither asserted, or at a limit): unchanged.
REQ-013 Overlap in CHECK SHALL be true when all of the following hold, with 9-bit unsigned compares and no wrap:
- xp+3 >= OBS_X
- xp <= OBS_X+OBS_SIZE-1
- yp+3 >= OBS_Y
- yp <= OBS_Y+OBS_SIZE-1
REQ-014 The finish condition SHALL be overlap OR xp >= X_END; collided SHALL be set to overlap, so a collision takes priority when both are true.
REQ-015 finish and collided SHALL be registered, rise in the cycle after CHECK, and remain sticky in DONE regardless of draw.
REQ-016 Latency SHALL be as follows, for a tick seen in WAIT at cycle t:
- ERASE occupies t+1..t+16.
- UPDATE occupies t+17.
- DRAW occupies t+18..t+33.
- CHECK occupies t+34.
- finish is visible at t+35 if the finish condition holds.
REQ-017 The first entry from IDLE SHALL paint the current position with no preceding erase, then CHECK.

Reset
REQ-018 While resetn=0 on a clock edge, the following SHALL hold in the next cycle:
- state = IDLE.
- xp = X_START, yp = Y_START.
- Tick counter and pixel counter = 0.
- finish = 0, collided = 0, plot = 0.
REQ-019 Reset SHALL take priority over every state, including mid-ERASE or mid-DRAW and DONE.

Verification
REQ-020 The bench SHALL use TICK_CYCLES=4 and cover the following directed scenarios:
- Reset then draw=1 and writeEnable=1 -> 16 plot pulses at (0..3, 56..59) with colour 010, then WAIT, finish=0.
- One tick, up=0, down=0 -> 16 black plots at x 0..3, then 16 colour-010 plots at x 1..4 on y 56..59; finish=0.
- up=1 held from yp=1 -> yp goes 0 and then stays 0; up=1 with down=1 -> yp unchanged.
- Free run at Y_START=56 -> collision when xp=77; finish=1, collided=1 exactly 35 cycles after the tick; DONE holds with draw=0.
- Y_START=0, no input -> xp reaches 156; finish=1, collided=0; no further plots.
- draw=0 at the 8th ERASE cycle -> plot=0 next cycle, xp unchanged, IDLE; resetn=0 in DONE -> finish=0, xp=0, yp=56.

Source files
------------

// File: rtl/obstacle_datapath.sv
// rtl/obstacle_datapath.sv - moves a 4x4 object right one pixel per tick, erasing/redrawing it
// and stopping at the right edge or on collision with a square obstacle.
module obstacle_datapath #(
  parameter int         TICK_CYCLES = 833333,
  parameter logic [7:0] X_START     = 8'd0,
  parameter logic [6:0] Y_START     = 7'd56,
  parameter logic [7:0] X_END       = 8'd156,
  parameter logic [7:0] OBS_X       = 8'd80,
  parameter logic [6:0] OBS_Y       = 7'd48,
  parameter int         OBS_SIZE    = 16,
  parameter logic [2:0] OBJ_COLOUR  = 3'b010
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       draw,
  input  logic       writeEnable,
  input  logic       up,
  input  logic       down,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       finish,
  output logic       collided
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  // Obstacle bounds widened to 9 bits so the edge arithmetic never wraps.
  localparam logic [8:0] OBS_X_LO = {1'b0, OBS_X};
  localparam logic [8:0] OBS_X_HI = {1'b0, OBS_X} + 9'(OBS_SIZE) - 9'd1;
  localparam logic [8:0] OBS_Y_LO = {2'b00, OBS_Y};
  localparam logic [8:0] OBS_Y_HI = {2'b00, OBS_Y} + 9'(OBS_SIZE) - 9'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ERASE, S_UPDATE, S_DRAW, S_CHECK, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q;
  logic [3:0]    p_q;
  logic [7:0]    xp_q;
  logic [6:0]    yp_q;
  logic          finish_q, collided_q;

  logic          tick;
  logic          overlap;
  logic          finish_cond;
  logic [6:0]    yp_next;
  logic [8:0]    xp9, yp9;

  always_ff @(posedge clock) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (draw) state_d = S_DRAW;
      S_WAIT:   if (tick) state_d = S_ERASE;
      S_ERASE:  if (p_q == 4'hF) state_d = S_UPDATE;
      S_UPDATE: state_d = S_DRAW;
      S_DRAW:   if (p_q == 4'hF) state_d = S_CHECK;
      S_CHECK:  state_d = finish_cond ? S_DONE : S_WAIT;
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
    if (state_q != S_DONE && !draw) state_d = S_IDLE;
  end

  always_comb begin
    tick        = (tick_q == TICK_LAST);
    xp9         = {1'b0, xp_q};
    yp9         = {2'b00, yp_q};
    overlap     = (xp9 + 9'd3 >= OBS_X_LO) && (xp9 <= OBS_X_HI) &&
                  (yp9 + 9'd3 >= OBS_Y_LO) && (yp9 <= OBS_Y_HI);
    finish_cond = overlap || (xp_q >= X_END);
    yp_next     = yp_q;
    if (up && !down && yp_q > 7'd0)          yp_next = yp_q - 7'd1;
    else if (down && !up && yp_q < 7'd116)   yp_next = yp_q + 7'd1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      tick_q     <= '0;
      p_q        <= 4'd0;
      xp_q       <= X_START;
      yp_q       <= Y_START;
      finish_q   <= 1'b0;
      collided_q <= 1'b0;
    end else begin
      tick_q <= (state_q == S_WAIT && state_d == S_WAIT) ? tick_q + 1'b1 : '0;
      // Pixel counter runs only while staying in the same paint phase.
      p_q <= ((state_q == S_ERASE || state_q == S_DRAW) && state_d == state_q)
             ? p_q + 4'd1 : 4'd0;
      if (state_q == S_UPDATE && state_d == S_DRAW) begin
        xp_q <= xp_q + 8'd1;
        yp_q <= yp_next;
      end
      if (state_q == S_CHECK && state_d == S_DONE) begin
        finish_q   <= 1'b1;
        collided_q <= overlap;
      end
    end
  end

  always_comb begin
    plot     = writeEnable && (state_q == S_ERASE || state_q == S_DRAW);
    colour   = (state_q == S_ERASE) ? 3'b000 : OBJ_COLOUR;
    x        = xp_q + {6'd0, p_q[1:0]};
    y        = yp_q + {5'd0, p_q[3:2]};
    finish   = finish_q;
    collided = collided_q;
  end

endmodule

// File: tb/tb_obstacle_datapath.sv
// tb/tb_obstacle_datapath.sv - directed bench: instance a starts at y=56, instance b at y=0.
module tb_obstacle_datapath;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetn, we;
  logic       a_draw, a_up, a_down, b_draw, b_up, b_down;
  logic [7:0] a_x, b_x;
  logic [6:0] a_y, b_y;
  logic [2:0] a_colour, b_colour;
  logic       a_plot, a_finish, a_collided, b_plot, b_finish, b_collided;

  int tests = 0;
  int fails = 0;

  obstacle_datapath #(.TICK_CYCLES(4), .Y_START(7'd56)) dut_a (
    .clock(clock), .resetn(resetn), .draw(a_draw), .writeEnable(we),
    .up(a_up), .down(a_down), .x(a_x), .y(a_y), .colour(a_colour),
    .plot(a_plot), .finish(a_finish), .collided(a_collided)
  );

  obstacle_datapath #(.TICK_CYCLES(4), .Y_START(7'd0)) dut_b (
    .clock(clock), .resetn(resetn), .draw(b_draw), .writeEnable(we),
    .up(b_up), .down(b_down), .x(b_x), .y(b_y), .colour(b_colour),
    .plot(b_plot), .finish(b_finish), .collided(b_collided)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Advance to the first pixel of the next DRAW phase of the selected instance.
  task automatic wait_draw(input bit sel, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200 && (sel ? b_plot : a_plot); n++) step(1);
    for (int n = 0; n < 200; n++) begin
      if ((sel ? b_plot : a_plot) && (sel ? b_colour : a_colour) == 3'b010) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic wait_erase(input bit sel, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if ((sel ? b_plot : a_plot) && (sel ? b_colour : a_colour) == 3'b000) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; we = 1'b1;
    a_draw = 1'b0; a_up = 1'b0; a_down = 1'b0;
    b_draw = 1'b0; b_up = 1'b0; b_down = 1'b0;
    step(2);
    tests++;
    if ({a_plot, a_finish, a_collided, b_finish, b_collided} !== 5'b0) begin
      fails++;
      $display("FAIL reset_state: got %b expected 00000",
               {a_plot, a_finish, a_collided, b_finish, b_collided});
    end
    resetn = 1'b1; a_draw = 1'b1;
    step(1);
    for (int i = 0; i < 16; i++) begin
      tests++;
      if ({a_plot, a_colour, a_x, a_y} !== {1'b1, 3'b010, 8'(i % 4), 7'(56 + i / 4)}) begin
        fails++;
        $display("FAIL first_draw[%0d]: got plot=%b col=%b x=%0d y=%0d expected 1 010 %0d %0d",
                 i, a_plot, a_colour, a_x, a_y, i % 4, 56 + i / 4);
      end
      step(1);
    end
    tests++;
    if (a_plot !== 1'b0) begin
      fails++;
      $display("FAIL check_no_plot: got %b expected 0", a_plot);
    end
    step(1);
    tests++;
    if ({a_plot, a_finish} !== 2'b00) begin
      fails++;
      $display("FAIL first_wait: got plot,finish=%b expected 00", {a_plot, a_finish});
    end
  endtask

  task automatic test_one_tick();
    step(3);
    tests++;
    if (a_plot !== 1'b0) begin
      fails++;
      $display("FAIL wait_len: got plot=%b expected 0", a_plot);
    end
    step(1);
    for (int i = 0; i < 16; i++) begin
      tests++;
      if ({a_plot, a_colour, a_x, a_y} !== {1'b1, 3'b000, 8'(i % 4), 7'(56 + i / 4)}) begin
        fails++;
        $display("FAIL erase[%0d]: got plot=%b col=%b x=%0d y=%0d expected 1 000 %0d %0d",
                 i, a_plot, a_colour, a_x, a_y, i % 4, 56 + i / 4);
      end
      step(1);
    end
    tests++;
    if (a_plot !== 1'b0) begin
      fails++;
      $display("FAIL update_no_plot: got %b expected 0", a_plot);
    end
    step(1);
    for (int i = 0; i < 16; i++) begin
      tests++;
      if ({a_plot, a_colour, a_x, a_y} !== {1'b1, 3'b010, 8'(1 + i % 4), 7'(56 + i / 4)}) begin
        fails++;
        $display("FAIL redraw[%0d]: got plot=%b col=%b x=%0d y=%0d expected 1 010 %0d %0d",
                 i, a_plot, a_colour, a_x, a_y, 1 + i % 4, 56 + i / 4);
      end
      step(1);
    end
    step(1);
    tests++;
    if ({a_plot, a_finish} !== 2'b00) begin
      fails++;
      $display("FAIL tick_finish: got plot,finish=%b expected 00", {a_plot, a_finish});
    end
  endtask

  task automatic test_collision();
    int exp_xp = 1;
    bit ok;
    for (int f = 0; f < 100; f++) begin
      wait_erase(1'b0, ok);
      if (!ok) begin
        tests++; fails++;
        $display("FAIL collision_erase_timeout: got none expected erase at xp=%0d", exp_xp);
        break;
      end
      step(33);
      exp_xp++;
      if (exp_xp == 77) begin
        tests++;
        if ({a_finish, a_collided} !== 2'b00) begin
          fails++;
          $display("FAIL collision_early: got %b expected 00 at tick+34", {a_finish, a_collided});
        end
        step(1);
        tests++;
        if ({a_finish, a_collided} !== 2'b11) begin
          fails++;
          $display("FAIL collision_flags: got %b expected 11 at tick+35", {a_finish, a_collided});
        end
        break;
      end
      step(1);
    end
    a_draw = 1'b0;
    step(5);
    tests++;
    if ({a_finish, a_collided, a_plot} !== 3'b110) begin
      fails++;
      $display("FAIL done_sticky: got %b expected 110", {a_finish, a_collided, a_plot});
    end
  endtask

  task automatic test_reset_in_done();
    bit ok;
    resetn = 1'b0;
    step(1);
    tests++;
    if ({a_finish, a_collided, a_plot} !== 3'b000) begin
      fails++;
      $display("FAIL reset_done: got %b expected 000", {a_finish, a_collided, a_plot});
    end
    resetn = 1'b1; a_draw = 1'b1;
    wait_draw(1'b0, ok);
    tests++;
    if (!ok || {a_x, a_y} !== {8'd0, 7'd56}) begin
      fails++;
      $display("FAIL reset_position: got ok=%b x=%0d y=%0d expected 1 0 56", ok, a_x, a_y);
    end
  endtask

  task automatic test_abort();
    bit ok;
    wait_erase(1'b0, ok);
    step(7);
    tests++;
    if (!ok || a_plot !== 1'b1 || a_x !== 8'd3 || a_y !== 7'd57) begin
      fails++;
      $display("FAIL abort_erase8: got ok=%b plot=%b x=%0d y=%0d expected 1 1 3 57",
               ok, a_plot, a_x, a_y);
    end
    a_draw = 1'b0;
    step(1);
    tests++;
    if (a_plot !== 1'b0) begin
      fails++;
      $display("FAIL abort_plot: got %b expected 0", a_plot);
    end
    step(5);
    tests++;
    if (a_plot !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: got %b expected 0", a_plot);
    end
    a_draw = 1'b1;
    wait_draw(1'b0, ok);
    tests++;
    if (!ok || {a_x, a_y} !== {8'd0, 7'd56}) begin
      fails++;
      $display("FAIL abort_xp_held: got ok=%b x=%0d y=%0d expected 1 0 56", ok, a_x, a_y);
    end
    a_draw = 1'b0;
  endtask

  task automatic test_updown();
    logic [1:0] ud [5] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b11};
    int         ey [5] = '{1, 0, 0, 1, 1};
    bit ok;
    b_draw = 1'b1;
    wait_draw(1'b1, ok);
    tests++;
    if (!ok || {b_x, b_y} !== {8'd0, 7'd0}) begin
      fails++;
      $display("FAIL b_first_draw: got ok=%b x=%0d y=%0d expected 1 0 0", ok, b_x, b_y);
    end
    for (int k = 0; k < 5; k++) begin
      {b_up, b_down} = ud[k];
      wait_draw(1'b1, ok);
      tests++;
      if (!ok || {b_x, b_y} !== {8'(k + 1), 7'(ey[k])}) begin
        fails++;
        $display("FAIL updown[%0d]: got ok=%b x=%0d y=%0d expected 1 %0d %0d",
                 k, ok, b_x, b_y, k + 1, ey[k]);
      end
    end
    b_up = 1'b0; b_down = 1'b0;
  endtask

  task automatic test_run_end();
    int exp_x = 6;
    int plots = 0;
    bit ok;
    while (exp_x <= 156) begin
      wait_draw(1'b1, ok);
      tests++;
      if (!ok || b_x !== 8'(exp_x) || b_finish !== 1'b0) begin
        fails++;
        $display("FAIL run_x: got ok=%b x=%0d finish=%b expected 1 %0d 0", ok, b_x, b_finish, exp_x);
        break;
      end
      exp_x++;
    end
    step(17);
    tests++;
    if ({b_finish, b_collided} !== 2'b10) begin
      fails++;
      $display("FAIL run_end_flags: got %b expected 10", {b_finish, b_collided});
    end
    for (int i = 0; i < 100; i++) begin
      if (b_plot) plots++;
      step(1);
    end
    tests++;
    if (plots != 0) begin
      fails++;
      $display("FAIL run_end_plots: got %0d expected 0", plots);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_one_tick();
    test_collision();
    test_reset_in_done();
    test_abort();
    test_updown();
    test_run_end();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
